// File: rtl/load_store_unit.sv
// Load/store unit: aligns RV32 byte/half/word accesses onto a 32-bit word bus and sign/zero-extends loads.
// Latency k+2 cycles (accept, k BUSY cycles until mem_ack, DONE); Stall holds the pipeline meanwhile, and a bus timeout faults.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Load,
  input  logic        Store,
  input  logic [2:0]  AddressingControl,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessFault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0]    code_q, code_d;
  logic [3:0]    be_q, be_d;
  logic          we_q, we_d, fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          req_vld, illegal, misaligned, legal;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata, shifted, load_val;

  // Request decode; Store wins when both are raised, so its code table applies.
  always_comb begin
    req_vld = Load | Store;
    if (Store)
      illegal = !(AddressingControl == 3'b000 || AddressingControl == 3'b001 ||
                  AddressingControl == 3'b010);
    else
      illegal = !(AddressingControl == 3'b000 || AddressingControl == 3'b001 ||
                  AddressingControl == 3'b010 || AddressingControl == 3'b100 ||
                  AddressingControl == 3'b101);
    misaligned = (AddressingControl[1:0] == 2'b01 && ALUResult[0]) ||
                 (AddressingControl[1:0] == 2'b10 && ALUResult[1:0] != 2'b00);
    legal = req_vld && !illegal && !misaligned;

    case (AddressingControl[1:0])
      2'b00:   begin lane_be = 4'b0001 << ALUResult[1:0]; lane_wdata = {4{WriteData[7:0]}}; end
      2'b01:   begin lane_be = 4'b0011 << ALUResult[1:0]; lane_wdata = {2{WriteData[15:0]}}; end
      default: begin lane_be = 4'b1111;                   lane_wdata = WriteData; end
    endcase
    if (!Store) lane_wdata = 32'h0;
  end

  always_comb begin
    shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    case (code_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    code_d  = code_q;
    be_d    = be_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal) begin
          state_d = BUSY;
          addr_d  = ALUResult;
          code_d  = AddressingControl;
          we_d    = Store;
          be_d    = lane_be;
          wdata_d = lane_wdata;
          cnt_d   = '0;
        end else if (req_vld) begin
          fault_d = 1'b1;
        end
      end
      BUSY: begin
        // An ack on the final allowed cycle still completes the access.
        if (mem_ack) begin
          state_d = DONE;
          if (!we_q) rdata_d = load_val;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            fault_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      code_q  <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      code_q  <= code_d;
      be_q    <= be_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign mem_req     = (state_q == BUSY);
  assign mem_we      = (state_q == BUSY) && we_q;
  assign mem_addr    = {addr_q[31:2], 2'b00};
  assign mem_wdata   = wdata_q;
  assign mem_be      = be_q;
  assign ReadData    = rdata_q;
  assign AccessFault = fault_q;
  assign Stall       = (state_q == BUSY) || (state_q == IDLE && legal);
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single transactions plus reset/timeout sequences.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Load = 1'b0, Store = 1'b0, mem_ack = 1'b0;
  logic [2:0]  AddressingControl = 3'b000;
  logic [31:0] ALUResult = '0, WriteData = '0, mem_rdata = '0;
  logic [31:0] ReadData, mem_addr, mem_wdata;
  logic        Stall, AccessFault, mem_req, mem_we;
  logic [3:0]  mem_be;

  int n_vec = 0;
  int n_err = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .Load(Load), .Store(Store),
    .AddressingControl(AddressingControl), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .AccessFault(AccessFault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld, st;
    logic [2:0]  code;
    logic [31:0] addr, wd, rdata;
    int          ack_k;                 // BUSY cycle number carrying ack; 0 = never
    int          exp_fault, exp_req, exp_stall;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic [31:0] exp_wdata, exp_rd;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] code,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                              input int ack_k, input int flt, input int req, input int stl,
                              input logic [31:0] eaddr, input logic [3:0] be, input logic we,
                              input logic [31:0] ewd, input logic [31:0] rd);
    vec_t v;
    v.ld = ld; v.st = st; v.code = code; v.addr = addr; v.wd = wd; v.rdata = rdata;
    v.ack_k = ack_k; v.exp_fault = flt; v.exp_req = req; v.exp_stall = stl;
    v.exp_addr = eaddr; v.exp_be = be; v.exp_we = we; v.exp_wdata = ewd; v.exp_rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic run(input int idx);
    vec_t v;
    int stall_n, req_n, flt_n, unstable;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    logic        we0;
    v = vecs[idx];
    stall_n = 0; req_n = 0; flt_n = 0; unstable = 0;
    a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0;
    @(negedge clk);
    Load = v.ld; Store = v.st; AddressingControl = v.code; ALUResult = v.addr; WriteData = v.wd;
    #1 if (Stall) stall_n++;
    @(posedge clk);
    #1 Load = 1'b0; Store = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (mem_req) begin
        req_n++;
        if (req_n == 1) begin
          a0 = mem_addr; w0 = mem_wdata; b0 = mem_be; we0 = mem_we;
        end else if ({mem_addr, mem_wdata, mem_be, mem_we} !== {a0, w0, b0, we0}) begin
          unstable++;
        end
        if (req_n == v.ack_k) begin
          mem_ack = 1'b1;
          mem_rdata = v.rdata;
        end
      end
      if (Stall) stall_n++;
      if (AccessFault) flt_n++;
      @(posedge clk);
      #1 mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    end
    check($sformatf("v%0d fault_cycles", idx), flt_n, v.exp_fault);
    check($sformatf("v%0d req_cycles", idx), req_n, v.exp_req);
    check($sformatf("v%0d stall_cycles", idx), stall_n, v.exp_stall);
    check($sformatf("v%0d ReadData", idx), ReadData, v.exp_rd);
    if (v.exp_req > 0) begin
      check($sformatf("v%0d mem_addr", idx), a0, v.exp_addr);
      check($sformatf("v%0d mem_be", idx), {28'h0, b0}, {28'h0, v.exp_be});
      check($sformatf("v%0d mem_we", idx), {31'h0, we0}, {31'h0, v.exp_we});
      check($sformatf("v%0d mem_wdata", idx), w0, v.exp_wdata);
      check($sformatf("v%0d bus_stable", idx), unstable, 0);
    end
  endtask

  initial begin
    //           ld    st    code    addr          wd            rdata        k  flt req stl exp_addr      be       we    wdata         ReadData
    vecs[0]  = mk(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 1, 0, 1, 2, 32'h0000_0100, 4'b1000, 1'b0, 32'h0,        32'hFFFF_FF80);
    vecs[1]  = mk(1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 32'hDEAD_BEEF, 1, 0, 1, 2, 32'h0000_0020, 4'b1100, 1'b1, 32'hABCD_ABCD, 32'hFFFF_FF80);
    vecs[2]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,         1, 1, 0, 0, 32'h0,        4'b0000, 1'b0, 32'h0,        32'hFFFF_FF80);
    vecs[3]  = mk(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'hBEEF_0000, 3, 0, 3, 4, 32'h0000_0000, 4'b1100, 1'b0, 32'h0,        32'h0000_BEEF);
    vecs[4]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0,        32'h0,         0, 1, 4, 5, 32'h0000_0040, 4'b1111, 1'b0, 32'h0,        32'h0000_BEEF);
    vecs[5]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0,        32'h1234_5678, 4, 0, 4, 5, 32'h0000_0044, 4'b1111, 1'b0, 32'h0,        32'h1234_5678);
    vecs[6]  = mk(1'b0, 1'b1, 3'b000, 32'h0000_0045, 32'h1234_56A5, 32'hFFFF_FFFF, 2, 0, 2, 3, 32'h0000_0044, 4'b0010, 1'b1, 32'hA5A5_A5A5, 32'h1234_5678);
    vecs[7]  = mk(1'b0, 1'b1, 3'b010, 32'h0000_0048, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1, 0, 1, 2, 32'h0000_0048, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h1234_5678);
    vecs[8]  = mk(1'b1, 1'b0, 3'b001, 32'h0000_004A, 32'hFFFF_FFFF, 32'h8001_0000, 1, 0, 1, 2, 32'h0000_0048, 4'b1100, 1'b0, 32'h0,        32'hFFFF_8001);
    vecs[9]  = mk(1'b1, 1'b0, 3'b100, 32'h0000_0041, 32'h0,        32'h0000_9A00, 1, 0, 1, 2, 32'h0000_0040, 4'b0010, 1'b0, 32'h0,        32'h0000_009A);
    vecs[10] = mk(1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,         1, 1, 0, 0, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0000_009A);
    vecs[11] = mk(1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,         1, 1, 0, 0, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0000_009A);
    vecs[12] = mk(1'b0, 1'b1, 3'b001, 32'h0000_0021, 32'h0,        32'h0,         1, 1, 0, 0, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0000_009A);
    vecs[13] = mk(1'b1, 1'b1, 3'b010, 32'h0000_0050, 32'h1111_2222, 32'hFFFF_FFFF, 1, 0, 1, 2, 32'h0000_0050, 4'b1111, 1'b1, 32'h1111_2222, 32'h0000_009A);
    vecs[14] = mk(1'b1, 1'b0, 3'b110, 32'h0000_0000, 32'h0,        32'h0,         1, 1, 0, 0, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0000_009A);

    // Reset state, checked while rst is held.
    #1;
    check("rst ReadData", ReadData, 32'h0);
    check("rst Stall", {31'h0, Stall}, 32'h0);
    check("rst AccessFault", {31'h0, AccessFault}, 32'h0);
    check("rst mem_req", {31'h0, mem_req}, 32'h0);
    check("rst mem_we", {31'h0, mem_we}, 32'h0);
    check("rst mem_be", {28'h0, mem_be}, 32'h0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 15; i++) run(i);

    // Reset in the second BUSY cycle abandons the load; a later ack is ignored.
    @(negedge clk);
    Load = 1'b1; AddressingControl = 3'b010; ALUResult = 32'h0000_0010;
    @(posedge clk);
    #1 Load = 1'b0;
    @(posedge clk);
    #1 check("r29 mem_req busy2", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    #1;
    check("r29 mem_req after rst", {31'h0, mem_req}, 32'h0);
    check("r29 Stall after rst", {31'h0, Stall}, 32'h0);
    check("r29 ReadData cleared", ReadData, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    check("r29 ReadData after stray ack", ReadData, 32'h0);
    check("r29 mem_req after stray ack", {31'h0, mem_req}, 32'h0);
    check("r29 Stall after stray ack", {31'h0, Stall}, 32'h0);
    check("r29 AccessFault after stray ack", {31'h0, AccessFault}, 32'h0);

    // Unit still works after the abandoned access.
    vecs[0].exp_rd = 32'hFFFF_FF80;
    run(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
